uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser.sv | 157 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// UART command frame parser: HDR0 HDR1 payload [xor] TAIL, with inter-byte timeout.
// Publishes the payload of the last good frame, one-cycle status pulses and saturating counters.
module uart_cmd_parser #(
  parameter int         DATA_BYTES  = 5,
  parameter logic [7:0] HDR0        = 8'h55,
  parameter logic [7:0] HDR1        = 8'hA5,
  parameter logic [7:0] TAIL        = 8'hF0,
  parameter bit         CHK_EN      = 1'b1,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_done,
  input  logic [7:0]              rx_data,
  output logic [DATA_BYTES*8-1:0] payload,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic [1:0]              err_code,
  output logic                    busy,
  output logic [CNT_W-1:0]        ok_cnt,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_H1,
    S_PAY,
    S_CHK,
    S_TAIL
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_BYTES*8-1:0] shadow;
  logic [IDX_W-1:0]        idx;
  logic [7:0]              chk;
  logic                    chk_bad;
  logic [TO_W-1:0]         to_cnt;
  logic                    timeout;
  logic                    good;
  logic                    bad;
  logic [1:0]              bad_code;

  assign busy = (state != S_IDLE);

  // A byte arriving in the same cycle as the timeout wins.
  always_comb begin
    timeout = 1'b0;
    if ((TIMEOUT_CYC > 0) && (state != S_IDLE) && !rx_done && (to_cnt == TO_LAST))
      timeout = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    good      = 1'b0;
    bad       = 1'b0;
    bad_code  = 2'd0;
    if (rx_done) begin
      case (state)
        S_IDLE: if (rx_data == HDR0) state_nxt = S_H1;
        S_H1: begin
          if (rx_data == HDR1)      state_nxt = S_PAY;
          else if (rx_data != HDR0) state_nxt = S_IDLE;
        end
        S_PAY:  if (idx == LAST_IDX) state_nxt = CHK_EN ? S_CHK : S_TAIL;
        S_CHK:  state_nxt = S_TAIL;
        S_TAIL: begin
          state_nxt = S_IDLE;
          if ((rx_data == TAIL) && !chk_bad) begin
            good = 1'b1;
          end else begin
            bad      = 1'b1;
            bad_code = chk_bad ? 2'd1 : 2'd2;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = S_IDLE;
      if (state != S_H1) begin
        bad      = 1'b1;
        bad_code = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame assembly happens in the shadow buffer; payload only moves on a good tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      idx     <= '0;
      chk     <= '0;
      chk_bad <= 1'b0;
    end else if (rx_done) begin
      if (state == S_H1 && rx_data == HDR1) begin
        idx     <= '0;
        chk     <= '0;
        chk_bad <= 1'b0;
      end else if (state == S_PAY) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (idx == IDX_W'(DATA_BYTES - 1 - i)) shadow[i*8 +: 8] <= rx_data;
        end
        idx <= idx + 1'b1;
        chk <= chk ^ rx_data;
      end else if (state == S_CHK) begin
        chk_bad <= (rx_data != chk);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (rx_done || (state == S_IDLE) || timeout || (TIMEOUT_CYC == 0)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      payload     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      ok_cnt      <= '0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= good;
      frame_err   <= bad;
      if (good) begin
        payload <= shadow;
        if (ok_cnt != {CNT_W{1'b1}}) ok_cnt <= ok_cnt + 1'b1;
      end
      if (bad) begin
        err_code <= bad_code;
        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: frame table, corner sequences and a randomized
// run scored against a frame-level reference model; a second 2-byte/no-checksum instance.
module tb_uart_cmd_parser;

  localparam int         DB  = 5;
  localparam int         TO  = 100;
  localparam int         CW  = 4;
  localparam int         SAT = (1 << CW) - 1;
  localparam logic [7:0] H0  = 8'h55;
  localparam logic [7:0] H1  = 8'hA5;
  localparam logic [7:0] TL  = 8'hF0;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_done;
  logic [7:0]      rx_data;
  logic [DB*8-1:0] payload;
  logic            frame_valid;
  logic            frame_err;
  logic [1:0]      err_code;
  logic            busy;
  logic [CW-1:0]   ok_cnt;
  logic [CW-1:0]   err_cnt;

  logic            rx_done_b;
  logic [7:0]      rx_data_b;
  logic [15:0]     payload_b;
  logic            frame_valid_b;
  logic            frame_err_b;
  logic [1:0]      err_code_b;
  logic            busy_b;
  logic [CW-1:0]   ok_cnt_b;
  logic [CW-1:0]   err_cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(.DATA_BYTES(DB), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .payload(payload), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_code(err_code), .busy(busy), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  uart_cmd_parser #(.DATA_BYTES(2), .CHK_EN(1'b0), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .rx_done(rx_done_b), .rx_data(rx_data_b),
    .payload(payload_b), .frame_valid(frame_valid_b), .frame_err(frame_err_b),
    .err_code(err_code_b), .busy(busy_b), .ok_cnt(ok_cnt_b), .err_cnt(err_cnt_b)
  );

  // Reference model: tracks header matching, then collects the frame body and judges it whole.
  int              m_phase;
  logic [7:0]      fq[$];
  int              m_idle;
  logic [DB*8-1:0] m_payload;
  bit              m_valid;
  bit              m_err;
  logic [1:0]      m_code;
  int              m_ok;
  int              m_errc;

  task automatic model_reset();
    m_phase = 0; fq.delete(); m_idle = 0; m_payload = '0;
    m_valid = 0; m_err = 0; m_code = 2'd0; m_ok = 0; m_errc = 0;
  endtask

  task automatic model_judge();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < DB; i++) x ^= fq[i];
    if (fq[DB] == x && fq[DB+1] == TL) begin
      m_payload = '0;
      for (int i = 0; i < DB; i++) m_payload = {m_payload[DB*8-9:0], fq[i]};
      m_valid = 1;
      if (m_ok < SAT) m_ok++;
    end else begin
      m_err  = 1;
      m_code = (fq[DB] != x) ? 2'd1 : 2'd2;
      if (m_errc < SAT) m_errc++;
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    m_valid = 0;
    m_err   = 0;
    if (v) begin
      m_idle = 0;
      if (m_phase == 0) begin
        if (b == H0) m_phase = 1;
      end else if (m_phase == 1) begin
        if (b == H1) begin
          m_phase = 2;
          fq.delete();
        end else if (b != H0) begin
          m_phase = 0;
        end
      end else begin
        fq.push_back(b);
        if (fq.size() == DB + 2) begin
          model_judge();
          m_phase = 0;
        end
      end
    end else if (m_phase != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        if (m_phase == 2) begin
          m_err  = 1;
          m_code = 2'd3;
          if (m_errc < SAT) m_errc++;
        end
        m_phase = 0;
        m_idle  = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    checkOutput("payload", 64'(payload), 64'(m_payload));
    checkOutput("frame_valid", 64'(frame_valid), 64'(m_valid));
    checkOutput("frame_err", 64'(frame_err), 64'(m_err));
    checkOutput("err_code", 64'(err_code), 64'(m_code));
    checkOutput("busy", 64'(busy), 64'(m_phase != 0));
    checkOutput("ok_cnt", 64'(ok_cnt), 64'(m_ok));
    checkOutput("err_cnt", 64'(err_cnt), 64'(m_errc));
  endtask

  // Called at a falling edge; returns at the next falling edge after scoring the outputs.
  task automatic applyStimulus(input bit v, input logic [7:0] b);
    rx_done = v;
    rx_data = b;
    model_step(v, b);
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic tick_b(input logic [7:0] b);
    rx_done_b = 1'b1;
    rx_data_b = b;
    applyStimulus(1'b0, 8'h00);
    rx_done_b = 1'b0;
  endtask

  task automatic random_frame();
    int         kind;
    int         cut;
    logic [7:0] x;
    logic [7:0] fr[$];
    kind = $urandom_range(0, 9);
    cut  = $urandom_range(0, DB + 2);
    x    = 8'h00;
    fr   = {H0, H1};
    for (int i = 0; i < DB; i++) begin
      fr.push_back(8'($urandom));
      x ^= fr[i+2];
    end
    fr.push_back(x);
    fr.push_back(TL);
    if (kind == 5) fr[DB+2] = x ^ 8'($urandom_range(1, 255));
    if (kind == 6) fr[DB+3] = TL ^ 8'($urandom_range(1, 255));
    if (kind == 7) begin
      fr.delete();
      repeat ($urandom_range(1, 4)) fr.push_back(8'($urandom));
    end
    for (int i = 0; i < fr.size(); i++) begin
      applyStimulus(1'b1, fr[i]);
      if (kind == 8 && i == cut) begin
        idle(TO + $urandom_range(0, 2));
        break;
      end
      if (kind == 9 && i == cut) idle(TO - 1);
      else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  typedef struct {
    logic [95:0] bytes;
    int          len;
    bit          valid;
    bit          err;
    logic [1:0]  code;
    logic [39:0] pay;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] good_frame[9] = '{8'h55, 8'hA5, 8'h00, 8'h00, 8'hC3, 8'h50, 8'h01, 8'h92, 8'hF0};
  logic [7:0] seq_q[$];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{bytes: 96'h55A50000C350019_2F0,    len: 9,  valid: 1, err: 0, code: 2'd0, pay: 40'h0000C35001};
    vecs[1] = '{bytes: 96'h55A50000C3500193F0,     len: 9,  valid: 0, err: 1, code: 2'd1, pay: 40'h0000C35001};
    vecs[2] = '{bytes: 96'h55A50000C3500192_0F,    len: 9,  valid: 0, err: 1, code: 2'd2, pay: 40'h0000C35001};
    vecs[3] = '{bytes: 96'h5555A5112233445511F0,   len: 10, valid: 1, err: 0, code: 2'd2, pay: 40'h1122334455};
    vecs[4] = '{bytes: 96'h123455A5AABBCCDDEEEEF0, len: 11, valid: 1, err: 0, code: 2'd2, pay: 40'hAABBCCDDEE};
    vecs[5] = '{bytes: 96'h557755A5010203040501F0, len: 11, valid: 1, err: 0, code: 2'd2, pay: 40'h0102030405};

    reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; rx_done_b = 1'b0; rx_data_b = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    $display("[TB] frame table");
    for (int v = 0; v < 6; v++) begin
      logic [95:0] bb;
      bb = vecs[v].bytes;
      for (int k = 0; k < vecs[v].len; k++)
        applyStimulus(1'b1, bb[8*(vecs[v].len-1-k) +: 8]);
      checkOutput($sformatf("vec%0d_valid", v), 64'(frame_valid), 64'(vecs[v].valid));
      checkOutput($sformatf("vec%0d_err", v), 64'(frame_err), 64'(vecs[v].err));
      checkOutput($sformatf("vec%0d_code", v), 64'(err_code), 64'(vecs[v].code));
      checkOutput($sformatf("vec%0d_payload", v), 64'(payload), 64'(vecs[v].pay));
    end
    idle(1);
    checkOutput("pulse_one_cycle", 64'(frame_valid), 64'd0);

    $display("[TB] payload timeout");
    seq_q = {8'h55, 8'hA5, 8'h01, 8'h02};
    foreach (seq_q[i]) applyStimulus(1'b1, seq_q[i]);
    idle(99);
    checkOutput("to_99_busy", 64'(busy), 64'd1);
    checkOutput("to_99_err", 64'(frame_err), 64'd0);
    idle(1);
    checkOutput("to_100_err", 64'(frame_err), 64'd1);
    checkOutput("to_100_code", 64'(err_code), 64'd3);
    checkOutput("to_100_busy", 64'(busy), 64'd0);
    checkOutput("to_payload_kept", 64'(payload), 64'h0102030405);

    $display("[TB] byte on the timeout cycle");
    foreach (seq_q[i]) applyStimulus(1'b1, seq_q[i]);
    idle(99);
    applyStimulus(1'b1, 8'h03);
    checkOutput("edge_busy", 64'(busy), 64'd1);
    checkOutput("edge_no_err", 64'(frame_err), 64'd0);
    seq_q = {8'h04, 8'h05, 8'h01, 8'hF0};
    foreach (seq_q[i]) applyStimulus(1'b1, seq_q[i]);
    checkOutput("edge_valid", 64'(frame_valid), 64'd1);

    $display("[TB] header timeout is silent");
    applyStimulus(1'b1, 8'h55);
    idle(100);
    checkOutput("h1_to_busy", 64'(busy), 64'd0);
    checkOutput("h1_to_err", 64'(frame_err), 64'd0);

    $display("[TB] 2-byte instance without checksum");
    seq_q = {8'h55, 8'hA5, 8'hAB, 8'hCD, 8'hF0};
    foreach (seq_q[i]) tick_b(seq_q[i]);
    checkOutput("b_valid", 64'(frame_valid_b), 64'd1);
    checkOutput("b_payload", 64'(payload_b), 64'hABCD);
    checkOutput("b_ok_cnt", 64'(ok_cnt_b), 64'd1);
    seq_q = {8'h55, 8'hA5, 8'h12, 8'h34, 8'h0F};
    foreach (seq_q[i]) tick_b(seq_q[i]);
    checkOutput("b_err", 64'(frame_err_b), 64'd1);
    checkOutput("b_code", 64'(err_code_b), 64'd2);
    checkOutput("b_payload_kept", 64'(payload_b), 64'hABCD);
    checkOutput("b_err_cnt", 64'(err_cnt_b), 64'd1);
    tick_b(8'h00);
    checkOutput("b_busy", 64'(busy_b), 64'd0);

    $display("[TB] randomized frames");
    repeat (250) begin
      random_frame();
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(TO + 1);

    $display("[TB] counter saturation");
    repeat (SAT + 1) begin
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, good_frame[i]);
      applyStimulus(1'b1, 8'h0F);
    end
    checkOutput("err_cnt_sat", 64'(err_cnt), 64'(SAT));
    repeat (SAT + 1) foreach (good_frame[i]) applyStimulus(1'b1, good_frame[i]);
    checkOutput("ok_cnt_sat", 64'(ok_cnt), 64'(SAT));

    $display("[TB] reset mid-payload");
    seq_q = {8'h55, 8'hA5, 8'h01, 8'h02};
    foreach (seq_q[i]) applyStimulus(1'b1, seq_q[i]);
    reset = 1'b1;
    #1;
    checkOutput("rst_payload", 64'(payload), 64'd0);
    checkOutput("rst_valid", 64'(frame_valid), 64'd0);
    checkOutput("rst_err", 64'(frame_err), 64'd0);
    checkOutput("rst_code", 64'(err_code), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ok_cnt", 64'(ok_cnt), 64'd0);
    checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    foreach (good_frame[i]) applyStimulus(1'b1, good_frame[i]);
    checkOutput("post_rst_valid", 64'(frame_valid), 64'd1);
    checkOutput("post_rst_payload", 64'(payload), 64'h0000C35001);
    checkOutput("post_rst_ok_cnt", 64'(ok_cnt), 64'd1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
